ypbpr_sync_insert: RTL and testbench
====================================

Name: ypbpr_sync_insert

Overview:
- Sits directly downstream of the RGB-to-YPbPr converter and directly upstream of the video DAC pins.
- Auto-detects the polarity of the incoming sync.
- Rescales Y into the range above black level and forces Pb/Pr to mid-scale during blanking.
- Inserts sync-on-Y (bi-level, optionally tri-level), so the component output is drivable with no separate sync wire.
- Registers everything and keeps sync, blank and pixel strobes aligned with the video.

Parameters:
- WIDTH, 8: bits per component.
- BLACK_LVL, 16: Y code for black/blanking level.
- SYNC_LVL, 0: Y code during sync tip.
- TRI_HI_LVL, 32: Y code for the positive half of tri-level sync (used only with the optional feature).
- CNT_W, 12: width of the sync phase counter.

Ports:
- clk  in  1  video clock
- reset_n  in  1  asynchronous active-low reset
- y_in  in  WIDTH  luma from converter (its green output)
- pb_in  in  WIDTH  Pb from converter (its blue output)
- pr_in  in  WIDTH  Pr from converter (its red output)
- hs_in  in  1  horizontal sync, either polarity
- vs_in  in  1  vertical sync, passed through
- cs_in  in  1  composite sync, same polarity as hs_in
- blank_in  in  1  active-high blanking, aligned with video
- pixel_in  in  1  pixel strobe, passed through
- y_out  out  WIDTH  Y with sync inserted
- pb_out  out  WIDTH  Pb, mid-scale when blanked or in sync
- pr_out  out  WIDTH  Pr, mid-scale when blanked or in sync
- hs_out  out  1  hs_in delayed 2 cycles, polarity unchanged
- vs_out  out  1  vs_in delayed 2 cycles
- cs_out  out  1  cs_in delayed 2 cycles
- pixel_out  out  1  pixel_in delayed 2 cycles
- locked  out  1  sync polarity measurement valid

Behaviour:
- Reset (reset_n low, asynchronous): all outputs and all pipeline registers are 0; locked=0; polarity is active-low; phase counter=1; measurement flags cleared.
- Pipeline: all paths are registered on every clk, unconditionally. Latency is exactly 2 cycles for video, sync, blank and pixel. pixel_in gates nothing.
- Polarity detector:
  - hs_in is registered once (hs_q).
  - The counter increments every clk while hs_in==hs_q, saturating at 2^CNT_W-1.
  - On hs_in!=hs_q (edge), the count is stored into hi_len if hs_q==1, otherwise into lo_len. The matching flag is set and the counter reloads to 1.
- Detector states:
  - HUNT: fewer than both flags set.
  - LOCK: both flags set. locked=1, pol_high=(hi_len<lo_len); equal lengths give active-low. Each new edge updates its length and re-evaluates pol_high.
  - LOST: the counter reaches saturation in any state. Clear both flags and locked, force active-low, return to HUNT on the next edge.
- sync_act = cs_in XNOR pol_high, i.e. cs_in==1 when active-high, cs_in==0 when active-low. It is evaluated in stage 1 from the stage-1 pol value.
- Stage 1 registers:
  - ys = y_in*(2^WIDTH-BLACK_LVL), full 2*WIDTH width.
  - sync_act, blank_in, pb_in, pr_in.
  - The delayed strobes.
- Stage 2 output mux, in priority order:
  - sync_act: y_out=SYNC_LVL, pb/pr=2^(WIDTH-1).
  - Else blank: y_out=BLACK_LVL, pb/pr=2^(WIDTH-1).
  - Else: y_out=BLACK_LVL+ys[2*WIDTH-1:WIDTH], pb/pr pass through.
- Scaling: with the defaults, y_in=0 gives 16 and y_in=255 gives 255. There is no overflow by construction.
- Simultaneous edge and saturation: the edge wins and the counter reloads.

Optional Feature:
- Macro YPBPR_SYNC_INSERT_TRILEVEL_EN.
- Defined:
  - Stage 1 also registers the first-half flag: phase counter <= (active-phase measured length >> 1), i.e. lo_len>>1 when active-low, else hi_len>>1.
  - During sync_act with locked=1: y_out=SYNC_LVL while the flag is set, TRI_HI_LVL after.
  - When unlocked: bi-level only.
- Not defined: bi-level sync only. No extra registers or comparator are synthesized.

Test Plan:
- Reset mid-line: assert reset_n=0 during active video → all outputs 0 and locked=0 immediately (asynchronous). Release → locked stays 0 until one high and one low hs phase have been measured.
- Active-low lines: hs low 64 clk / high 736 clk, cs=hs → locked after second edge, pol_high=0; sync period gives y_out=0, pb_out=pr_out=128, exactly 2 clk after cs_in falls.
- Active-high lines: hs high 64 / low 736, cs=hs → pol_high=1; sync inserted when cs_in=1. Switch polarity mid-run → re-evaluated within one line.
- Scaling: blank=0, y_in=0 / 128 / 255, pb=10, pr=200 → y_out=16 / 136 / 255, pb_out=10, pr_out=200, latency 2.
- Loss of sync: hold hs_in constant 4095+ clk → locked drops and polarity reverts to active-low; blank_in=1 then gives y_out=16, pb=pr=128.
- With YPBPR_SYNC_INSERT_TRILEVEL_EN, active-low hs 64 clk, locked → y_out=0 for the first 32 sync clocks, then 32 for the remaining 32, then returns to the blank/video value.

Source files
------------

// File: rtl/ypbpr_sync_insert_if.sv
// ---------------------------------------------------------------------------
// ypbpr_sync_insert_if
// Bundles the video/sync input bus coming from the RGB-to-YPbPr converter and
// the DAC-facing output bus of ypbpr_sync_insert.
//   master : drives y_in/pb_in/pr_in/hs_in/vs_in/cs_in/blank_in/pixel_in,
//            observes y_out/pb_out/pr_out/hs_out/vs_out/cs_out/pixel_out/locked
//   slave  : the sync inserter itself (mirror directions)
// Parameter WIDTH: bits per colour component.
// ---------------------------------------------------------------------------
interface ypbpr_sync_insert_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] y_in;
    logic [WIDTH-1:0] pb_in;
    logic [WIDTH-1:0] pr_in;
    logic             hs_in;
    logic             vs_in;
    logic             cs_in;
    logic             blank_in;
    logic             pixel_in;

    logic [WIDTH-1:0] y_out;
    logic [WIDTH-1:0] pb_out;
    logic [WIDTH-1:0] pr_out;
    logic             hs_out;
    logic             vs_out;
    logic             cs_out;
    logic             pixel_out;
    logic             locked;

    modport master (
        output y_in, pb_in, pr_in, hs_in, vs_in, cs_in, blank_in, pixel_in,
        input  y_out, pb_out, pr_out, hs_out, vs_out, cs_out, pixel_out, locked
    );

    modport slave (
        input  y_in, pb_in, pr_in, hs_in, vs_in, cs_in, blank_in, pixel_in,
        output y_out, pb_out, pr_out, hs_out, vs_out, cs_out, pixel_out, locked
    );
endinterface

// File: rtl/ypbpr_sync_insert.sv
// ---------------------------------------------------------------------------
// ypbpr_sync_insert
// Sits between the RGB-to-YPbPr converter and the video DAC. Detects the
// polarity of the incoming horizontal sync, rescales Y above black level,
// forces Pb/Pr to mid-scale while blanked or in sync, and inserts sync-on-Y.
// Every path is a fixed two-register pipeline.
//
// Ports:
//   clk      video clock
//   reset_n  asynchronous active-low reset
//   bus      ypbpr_sync_insert_if.slave
//            in : y_in, pb_in, pr_in, hs_in, vs_in, cs_in, blank_in, pixel_in
//            out: y_out, pb_out, pr_out, hs_out, vs_out, cs_out, pixel_out,
//                 locked
//
// Optional feature macro: YPBPR_SYNC_INSERT_TRILEVEL_EN
//   When defined and the detector is locked, the sync tip is SYNC_LVL for the
//   first half of the measured sync phase and TRI_HI_LVL for the second half.
//   When undefined, sync is bi-level only.
// ---------------------------------------------------------------------------
module ypbpr_sync_insert #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned BLACK_LVL  = 16,
    parameter int unsigned SYNC_LVL   = 0,
    parameter int unsigned TRI_HI_LVL = 32,
    parameter int unsigned CNT_W      = 12
) (
    input  logic               clk,
    input  logic               reset_n,
    ypbpr_sync_insert_if.slave bus
);

    localparam logic [CNT_W-1:0]   CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CntOne = CNT_W'(1);
    // 2^WIDTH - BLACK_LVL: maps full-scale Y onto the span above black
    localparam logic [2*WIDTH-1:0] ScaleK = (2*WIDTH)'((1 << WIDTH) - BLACK_LVL);
    localparam logic [WIDTH-1:0]   MidLvl = WIDTH'(1 << (WIDTH - 1));
    localparam logic [WIDTH-1:0]   BlackY = WIDTH'(BLACK_LVL);
    localparam logic [WIDTH-1:0]   SyncY  = WIDTH'(SYNC_LVL);
`ifdef YPBPR_SYNC_INSERT_TRILEVEL_EN
    localparam logic [WIDTH-1:0]   TriY   = WIDTH'(TRI_HI_LVL);
`else
    // Keeps the parameter list identical between builds
    localparam int unsigned unused_tri_hi_lvl = TRI_HI_LVL;
`endif

    // -----------------------------------------------------------------------
    // Polarity detector
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        StHunt,
        StLock,
        StLost
    } det_state_e;

    det_state_e       r_state;
    logic             r_hs_q;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hi_len;
    logic [CNT_W-1:0] r_lo_len;
    logic             r_hi_vld;
    logic             r_lo_vld;
    logic             r_locked;
    logic             r_pol_high;

    logic             w_edge;
    logic             w_sat;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_hi_new;
    logic [CNT_W-1:0] w_lo_new;
    logic             w_both_vld;

    assign w_edge = (bus.hs_in != r_hs_q);
    assign w_sat  = (r_cnt == CntMax);

    // Counter value for the current cycle: 1 on the first cycle of a phase,
    // i.e. the 1-based position inside the running hs phase.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_edge) begin
            w_cnt_next = CntOne;
        end else if (!w_sat) begin
            w_cnt_next = r_cnt + CntOne;
        end
    end

    // The phase that just ended has the level held in r_hs_q
    assign w_hi_new   = (w_edge && r_hs_q)  ? r_cnt : r_hi_len;
    assign w_lo_new   = (w_edge && !r_hs_q) ? r_cnt : r_lo_len;
    assign w_both_vld = (r_hi_vld || r_hs_q) && (r_lo_vld || !r_hs_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StHunt;
            r_hs_q     <= 1'b0;
            r_cnt      <= CntOne;
            r_hi_len   <= '0;
            r_lo_len   <= '0;
            r_hi_vld   <= 1'b0;
            r_lo_vld   <= 1'b0;
            r_locked   <= 1'b0;
            r_pol_high <= 1'b0;
        end else begin
            r_hs_q <= bus.hs_in;
            r_cnt  <= w_cnt_next;
            if (w_sat && !w_edge) begin
                // No edge for a full counter range: sync is gone
                r_state    <= StLost;
                r_hi_vld   <= 1'b0;
                r_lo_vld   <= 1'b0;
                r_locked   <= 1'b0;
                r_pol_high <= 1'b0;
            end else if (w_edge) begin
                unique case (r_state)
                    StHunt, StLock: begin
                        r_hi_len <= w_hi_new;
                        r_lo_len <= w_lo_new;
                        if (r_hs_q) begin
                            r_hi_vld <= 1'b1;
                        end else begin
                            r_lo_vld <= 1'b1;
                        end
                        if (w_both_vld) begin
                            r_state    <= StLock;
                            r_locked   <= 1'b1;
                            // Shorter phase is the sync pulse; a tie means active-low
                            r_pol_high <= (w_hi_new < w_lo_new);
                        end
                    end
                    // The phase that ends here was saturated, so it is not recorded
                    StLost: r_state <= StHunt;
                    default: r_state <= StHunt;
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1
    // -----------------------------------------------------------------------
    logic [2*WIDTH-1:0] r_ys;
    logic               r_sync_act;
    logic               r_blank_s1;
    logic [WIDTH-1:0]   r_pb_s1;
    logic [WIDTH-1:0]   r_pr_s1;
    logic               r_vs_s1;
    logic               r_cs_s1;
    logic               r_pix_s1;

    logic [2*WIDTH-1:0] w_ys;
    logic               w_sync_act;

    assign w_ys       = {{WIDTH{1'b0}}, bus.y_in} * ScaleK;
    // Sync is active when cs_in sits at the detected active level
    assign w_sync_act = ~(bus.cs_in ^ r_pol_high);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ys       <= '0;
            r_sync_act <= 1'b0;
            r_blank_s1 <= 1'b0;
            r_pb_s1    <= '0;
            r_pr_s1    <= '0;
            r_vs_s1    <= 1'b0;
            r_cs_s1    <= 1'b0;
            r_pix_s1   <= 1'b0;
        end else begin
            r_ys       <= w_ys;
            r_sync_act <= w_sync_act;
            r_blank_s1 <= bus.blank_in;
            r_pb_s1    <= bus.pb_in;
            r_pr_s1    <= bus.pr_in;
            r_vs_s1    <= bus.vs_in;
            r_cs_s1    <= bus.cs_in;
            r_pix_s1   <= bus.pixel_in;
        end
    end

`ifdef YPBPR_SYNC_INSERT_TRILEVEL_EN
    logic             r_first_half;
    logic             r_tri_en;
    logic [CNT_W-1:0] w_act_len;

    // Measured length of the phase that carries the sync pulse
    assign w_act_len = r_pol_high ? r_hi_len : r_lo_len;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_first_half <= 1'b0;
            r_tri_en     <= 1'b0;
        end else begin
            r_first_half <= (w_cnt_next <= (w_act_len >> 1));
            r_tri_en     <= r_locked;
        end
    end
`endif

    // Only the upper half of the product is used; the low half is dropped
    logic unused_ys_lo;
    assign unused_ys_lo = ^r_ys[WIDTH-1:0];

    // -----------------------------------------------------------------------
    // Stage 2: output mux, sync > blank > video
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] w_y_nxt;
    logic [WIDTH-1:0] w_pb_nxt;
    logic [WIDTH-1:0] w_pr_nxt;

    always_comb begin
        w_y_nxt  = BlackY + r_ys[2*WIDTH-1:WIDTH];
        w_pb_nxt = r_pb_s1;
        w_pr_nxt = r_pr_s1;
        if (r_sync_act) begin
            w_y_nxt = SyncY;
`ifdef YPBPR_SYNC_INSERT_TRILEVEL_EN
            if (r_tri_en && !r_first_half) begin
                w_y_nxt = TriY;
            end
`endif
            w_pb_nxt = MidLvl;
            w_pr_nxt = MidLvl;
        end else if (r_blank_s1) begin
            w_y_nxt  = BlackY;
            w_pb_nxt = MidLvl;
            w_pr_nxt = MidLvl;
        end
    end

    logic [WIDTH-1:0] r_y_out;
    logic [WIDTH-1:0] r_pb_out;
    logic [WIDTH-1:0] r_pr_out;
    logic             r_hs_s2;
    logic             r_vs_s2;
    logic             r_cs_s2;
    logic             r_pix_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_y_out  <= '0;
            r_pb_out <= '0;
            r_pr_out <= '0;
            r_hs_s2  <= 1'b0;
            r_vs_s2  <= 1'b0;
            r_cs_s2  <= 1'b0;
            r_pix_s2 <= 1'b0;
        end else begin
            r_y_out  <= w_y_nxt;
            r_pb_out <= w_pb_nxt;
            r_pr_out <= w_pr_nxt;
            // r_hs_q doubles as the stage-1 copy of hs_in
            r_hs_s2  <= r_hs_q;
            r_vs_s2  <= r_vs_s1;
            r_cs_s2  <= r_cs_s1;
            r_pix_s2 <= r_pix_s1;
        end
    end

    assign bus.y_out     = r_y_out;
    assign bus.pb_out    = r_pb_out;
    assign bus.pr_out    = r_pr_out;
    assign bus.hs_out    = r_hs_s2;
    assign bus.vs_out    = r_vs_s2;
    assign bus.cs_out    = r_cs_s2;
    assign bus.pixel_out = r_pix_s2;
    assign bus.locked    = r_locked;

endmodule

// File: tb/tb_ypbpr_sync_insert.sv
// ---------------------------------------------------------------------------
// tb_ypbpr_sync_insert
// Directed bench for ypbpr_sync_insert: reset, active-low and active-high
// line locking with sync insertion, Y scaling, and loss of sync.
// ---------------------------------------------------------------------------
module tb_ypbpr_sync_insert;

`ifdef YPBPR_SYNC_INSERT_TRILEVEL_EN
    localparam bit TriBuild = 1'b1;
`else
    localparam bit TriBuild = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    ypbpr_sync_insert_if #(.WIDTH(8)) bus ();

    ypbpr_sync_insert #(
        .WIDTH      (8),
        .BLACK_LVL  (16),
        .SYNC_LVL   (0),
        .TRI_HI_LVL (32),
        .CNT_W      (12)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Expected output for the inputs applied two cycles earlier
    typedef struct packed {
        logic       v;
        logic [7:0] y;
        logic [7:0] pb;
        logic [7:0] pr;
        logic       hs;
        logic       vs;
        logic       cs;
        logic       pix;
    } exp_t;

    exp_t d1;
    exp_t d2;

    function automatic logic [27:0] got_vec();
        return {bus.y_out, bus.pb_out, bus.pr_out,
                bus.hs_out, bus.vs_out, bus.cs_out, bus.pixel_out};
    endfunction

    function automatic logic [27:0] want_vec(input exp_t e);
        return {e.y, e.pb, e.pr, e.hs, e.vs, e.cs, e.pix};
    endfunction

    // Record expectation for the current inputs, advance one clock, sample
    // on the falling edge and shift the expectation pipeline.
    task automatic tick(input bit chk, input logic [7:0] ey, input logic [7:0] epb,
                        input logic [7:0] epr);
        exp_t now;
        now.v   = chk;
        now.y   = ey;
        now.pb  = epb;
        now.pr  = epr;
        now.hs  = bus.hs_in;
        now.vs  = bus.vs_in;
        now.cs  = bus.cs_in;
        now.pix = bus.pixel_in;
        @(posedge clk);
        @(negedge clk);
        d2 = d1;
        d1 = now;
    endtask

    task automatic clear_exp();
        d1 = '0;
        d2 = '0;
    endtask

    // One 800-clock line: hs at the active level for 64 clocks, cs = hs,
    // blanked for the first 160 clocks, flat grey video (y=128) afterwards.
    task automatic run_line(input bit act_high, input bit chk, input bit tri_ok);
        for (int i = 0; i < 800; i++) begin
            logic       h;
            logic [7:0] ey;
            logic [7:0] epb;
            logic [7:0] epr;
            h = (i < 64) ? act_high : ~act_high;
            bus.hs_in    = h;
            bus.cs_in    = h;
            bus.blank_in = (i < 160);
            bus.y_in     = 8'd128;
            bus.pb_in    = 8'd10;
            bus.pr_in    = 8'd200;
            bus.vs_in    = (i >= 400);
            bus.pixel_in = ((i % 2) == 1);
            if (i < 64) begin
                ey  = (TriBuild && tri_ok && i >= 32) ? 8'd32 : 8'd0;
                epb = 8'd128;
                epr = 8'd128;
            end else if (i < 160) begin
                ey  = 8'd16;
                epb = 8'd128;
                epr = 8'd128;
            end else begin
                ey  = 8'd136;
                epb = 8'd10;
                epr = 8'd200;
            end
            tick(chk, ey, epb, epr);
            if (d2.v) begin
                n_checks++;
                if (got_vec() !== want_vec(d2)) begin
                    n_errors++;
                    $display("FAIL line_pipe t=%0t pos=%0d got y=%0d pb=%0d pr=%0d hvcp=%b%b%b%b want y=%0d pb=%0d pr=%0d hvcp=%b%b%b%b",
                             $time, i, bus.y_out, bus.pb_out, bus.pr_out, bus.hs_out,
                             bus.vs_out, bus.cs_out, bus.pixel_out, d2.y, d2.pb, d2.pr,
                             d2.hs, d2.vs, d2.cs, d2.pix);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n      = 1'b1;
        bus.y_in     = '0;
        bus.pb_in    = '0;
        bus.pr_in    = '0;
        bus.hs_in    = 1'b0;
        bus.vs_in    = 1'b0;
        bus.cs_in    = 1'b0;
        bus.blank_in = 1'b0;
        bus.pixel_in = 1'b0;
        clear_exp();
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({got_vec(), bus.locked} !== 29'd0) begin
            n_errors++;
            $display("FAIL reset_initial got %h want 0", {got_vec(), bus.locked});
        end
        @(negedge clk);
        // Active video, hs/cs high (inactive for the default active-low)
        bus.hs_in    = 1'b1;
        bus.cs_in    = 1'b1;
        bus.y_in     = 8'd255;
        bus.pb_in    = 8'd10;
        bus.pr_in    = 8'd200;
        bus.vs_in    = 1'b1;
        bus.pixel_in = 1'b1;
        reset_n      = 1'b1;
        repeat (20) begin
            tick(1'b1, 8'd255, 8'd10, 8'd200);
            if (d2.v) begin
                n_checks++;
                if (got_vec() !== want_vec(d2)) begin
                    n_errors++;
                    $display("FAIL pre_reset_video got %h want %h", got_vec(), want_vec(d2));
                end
            end
        end
        // Asynchronous reset between clock edges
        #3 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({got_vec(), bus.locked} !== 29'd0) begin
            n_errors++;
            $display("FAIL reset_async got %h want 0", {got_vec(), bus.locked});
        end
        clear_exp();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({got_vec(), bus.locked} !== 29'd0) begin
            n_errors++;
            $display("FAIL reset_held got %h want 0", {got_vec(), bus.locked});
        end
        bus.hs_in = 1'b0;
        bus.cs_in = 1'b0;
        reset_n   = 1'b1;
    endtask

    task automatic test_active_low();
        run_line(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (bus.locked !== 1'b0) begin
            n_errors++;
            $display("FAIL lock_one_phase got %b want 0", bus.locked);
        end
        run_line(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (bus.locked !== 1'b1) begin
            n_errors++;
            $display("FAIL lock_active_low got %b want 1", bus.locked);
        end
        run_line(1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_active_high();
        run_line(1'b1, 1'b0, 1'b0);
        run_line(1'b1, 1'b0, 1'b0);
        run_line(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (bus.locked !== 1'b1) begin
            n_errors++;
            $display("FAIL lock_active_high got %b want 1", bus.locked);
        end
    endtask

    // Polarity is active-high here, so hs=cs=0 is outside sync
    task automatic test_scaling();
        logic [7:0] vy [4] = '{8'd0, 8'd128, 8'd255, 8'd200};
        logic       vb [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] ey [4] = '{8'd16, 8'd136, 8'd255, 8'd16};
        logic [7:0] ep [4] = '{8'd10, 8'd10, 8'd10, 8'd128};
        logic [7:0] er [4] = '{8'd200, 8'd200, 8'd200, 8'd128};
        bus.hs_in = 1'b0;
        bus.cs_in = 1'b0;
        bus.pb_in = 8'd10;
        bus.pr_in = 8'd200;
        for (int k = 0; k < 6; k++) begin
            int j;
            j = (k < 4) ? k : 3;
            bus.y_in     = vy[j];
            bus.blank_in = vb[j];
            bus.vs_in    = (k % 2) == 0;
            bus.pixel_in = (k % 3) == 0;
            tick(k < 4, ey[j], ep[j], er[j]);
            if (d2.v) begin
                n_checks++;
                if (got_vec() !== want_vec(d2)) begin
                    n_errors++;
                    $display("FAIL scaling step=%0d got y=%0d pb=%0d pr=%0d want y=%0d pb=%0d pr=%0d",
                             k, bus.y_out, bus.pb_out, bus.pr_out, d2.y, d2.pb, d2.pr);
                end
            end
        end
    endtask

    task automatic test_loss();
        bus.hs_in    = 1'b0;
        bus.cs_in    = 1'b0;
        bus.blank_in = 1'b0;
        bus.y_in     = 8'd77;
        bus.pb_in    = 8'd3;
        bus.pr_in    = 8'd250;
        repeat (4200) tick(1'b0, 8'd0, 8'd0, 8'd0);
        n_checks++;
        if (bus.locked !== 1'b0) begin
            n_errors++;
            $display("FAIL loss_locked got %b want 0", bus.locked);
        end
        // Back to active-low: cs=1 is outside sync, so blank level shows
        bus.cs_in    = 1'b1;
        bus.blank_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) bus.cs_in = 1'b0;
            if (k < 4) begin
                tick(1'b1, 8'd16, 8'd128, 8'd128);
            end else if (k < 8) begin
                tick(1'b1, 8'd0, 8'd128, 8'd128);
            end else begin
                tick(1'b0, 8'd0, 8'd0, 8'd0);
            end
            if (d2.v) begin
                n_checks++;
                if (got_vec() !== want_vec(d2)) begin
                    n_errors++;
                    $display("FAIL loss_output step=%0d got y=%0d pb=%0d pr=%0d want y=%0d pb=%0d pr=%0d",
                             k, bus.y_out, bus.pb_out, bus.pr_out, d2.y, d2.pb, d2.pr);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_active_low();
        test_active_high();
        test_scaling();
        test_loss();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
